// File: rtl/fmap_pkg.sv
// Shared widths and loader state encoding for the feature-map write path.
package fmap_pkg;

   localparam int unsigned FMAP_ADDR_W    = 13;
   localparam int unsigned FMAP_DATA_W    = 64;
   localparam int unsigned FMAP_NUM_BANKS = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } fmap_ld_state_t;

endpackage : fmap_pkg

// File: rtl/fmap_row_loader_if.sv
// Command, input stream and row-write bus of the feature-map row loader.
interface fmap_row_loader_if #(
   parameter int unsigned DATA_W    = fmap_pkg::FMAP_DATA_W,
   parameter int unsigned NUM_BANKS = fmap_pkg::FMAP_NUM_BANKS,
   parameter int unsigned ADDR_W    = fmap_pkg::FMAP_ADDR_W
);

   logic                          start;
   logic [ADDR_W-1:0]             base_addr;
   logic [ADDR_W:0]               num_rows;
   logic [DATA_W-1:0]             in_data;
   logic                          in_valid;
   logic                          in_ready;
   logic                          fmap_wr_en;
   logic [ADDR_W-1:0]             fmap_wr_addr;
   logic [NUM_BANKS*DATA_W-1:0]   fmap_wr_data;
   logic                          busy;
   logic                          done;

   modport master (
      output start, base_addr, num_rows, in_data, in_valid,
      input  in_ready, fmap_wr_en, fmap_wr_addr, fmap_wr_data, busy, done
   );

   modport slave (
      input  start, base_addr, num_rows, in_data, in_valid,
      output in_ready, fmap_wr_en, fmap_wr_addr, fmap_wr_data, busy, done
   );

endinterface : fmap_row_loader_if

// File: rtl/fmap_row_packer.sv
// Row register: one word per bank, written by index, presented as a flat row.
module fmap_row_packer
   import fmap_pkg::*;
#(
   parameter int unsigned DATA_W    = FMAP_DATA_W,
   parameter int unsigned NUM_BANKS = FMAP_NUM_BANKS,
   parameter int unsigned IDX_W     = $clog2(NUM_BANKS)
) (
   input  logic                        clk,
   input  logic                        i_we,
   input  logic [IDX_W-1:0]            i_idx,
   input  logic [DATA_W-1:0]           i_data,
   output logic [NUM_BANKS*DATA_W-1:0] o_row
);

   logic [DATA_W-1:0] r_bank [NUM_BANKS];

   always_ff @(posedge clk) begin
      if (i_we) r_bank[i_idx] <= i_data;
   end

   for (genvar k = 0; k < NUM_BANKS; k++) begin : g_flat
      assign o_row[k*DATA_W +: DATA_W] = r_bank[k];
   end

endmodule : fmap_row_packer

// File: rtl/fmap_row_loader.sv
// Packs 16 streamed words per row and writes each row to the feature-map
// buffer at consecutive (wrapping) row addresses.
module fmap_row_loader
   import fmap_pkg::*;
#(
   parameter int unsigned DATA_W    = FMAP_DATA_W,
   parameter int unsigned NUM_BANKS = FMAP_NUM_BANKS,
   parameter int unsigned ADDR_W    = FMAP_ADDR_W
) (
   input  logic              core_clk,
   input  logic              core_rst,
   fmap_row_loader_if.slave  bus
);

   localparam int unsigned IDX_W = $clog2(NUM_BANKS);
   localparam int unsigned CNT_W = ADDR_W + 1;

   fmap_ld_state_t     r_state,      w_state_nxt;
   logic [IDX_W-1:0]   r_bank_idx,   w_bank_idx_nxt;
   logic [CNT_W-1:0]   r_row_cnt,    w_row_cnt_nxt;
   logic [CNT_W-1:0]   r_num_rows,   w_num_rows_nxt;
   logic [ADDR_W-1:0]  r_base,       w_base_nxt;
   logic [ADDR_W-1:0]  r_wr_addr,    w_wr_addr_nxt;
   logic               r_in_ready;
   logic               r_wr_en;
   logic               r_busy;
   logic               r_done;
   logic               w_accept;
   logic               w_last_bank;
   logic [NUM_BANKS*DATA_W-1:0] w_row;

   assign w_accept    = r_in_ready & bus.in_valid;
   assign w_last_bank = (r_bank_idx == IDX_W'(NUM_BANKS - 1));

   // State, counters and registered outputs
   always_ff @(posedge core_clk or posedge core_rst) begin
      if (core_rst) begin
         r_state    <= IDLE;
         r_bank_idx <= '0;
         r_row_cnt  <= '0;
         r_num_rows <= '0;
         r_base     <= '0;
         r_wr_addr  <= '0;
         r_in_ready <= 1'b0;
         r_wr_en    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_bank_idx <= w_bank_idx_nxt;
         r_row_cnt  <= w_row_cnt_nxt;
         r_num_rows <= w_num_rows_nxt;
         r_base     <= w_base_nxt;
         r_wr_addr  <= w_wr_addr_nxt;
         r_in_ready <= (w_state_nxt == FILL);
         r_wr_en    <= (w_state_nxt == WRITE);
         r_busy     <= (w_state_nxt != IDLE);
         r_done     <= (w_state_nxt == DONE);
      end
   end

   // Next-state and counter updates
   always_comb begin
      w_state_nxt    = r_state;
      w_bank_idx_nxt = r_bank_idx;
      w_row_cnt_nxt  = r_row_cnt;
      w_num_rows_nxt = r_num_rows;
      w_base_nxt     = r_base;
      w_wr_addr_nxt  = r_wr_addr;

      unique case (r_state)
         IDLE: begin
            if (bus.start) begin
               if (bus.num_rows != '0) begin
                  w_base_nxt     = bus.base_addr;
                  w_num_rows_nxt = bus.num_rows;
                  w_bank_idx_nxt = '0;
                  w_row_cnt_nxt  = '0;
                  w_state_nxt    = FILL;
               end else begin
                  w_state_nxt    = DONE;
               end
            end
         end
         FILL: begin
            if (w_accept) begin
               if (w_last_bank) begin
                  w_bank_idx_nxt = '0;
                  // Address is prepared here so it is a clean register in WRITE
                  w_wr_addr_nxt  = r_base + ADDR_W'(r_row_cnt);
                  w_state_nxt    = WRITE;
               end else begin
                  w_bank_idx_nxt = r_bank_idx + IDX_W'(1);
               end
            end
         end
         WRITE: begin
            w_row_cnt_nxt = r_row_cnt + CNT_W'(1);
            w_state_nxt   = (w_row_cnt_nxt == r_num_rows) ? DONE : FILL;
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   fmap_row_packer #(
      .DATA_W    (DATA_W),
      .NUM_BANKS (NUM_BANKS),
      .IDX_W     (IDX_W)
   ) u_packer (
      .clk    (core_clk),
      .i_we   (w_accept),
      .i_idx  (r_bank_idx),
      .i_data (bus.in_data),
      .o_row  (w_row)
   );

   assign bus.in_ready     = r_in_ready;
   assign bus.fmap_wr_en   = r_wr_en;
   assign bus.fmap_wr_addr = r_wr_addr;
   assign bus.fmap_wr_data = w_row;
   assign bus.busy         = r_busy;
   assign bus.done         = r_done;

endmodule : fmap_row_loader

// File: doc/fmap_row_loader.md
# fmap_row_loader

Write-side feeder for the 16-bank feature-map buffer. It accepts a stream of 64-bit words from the DMA/input path over a valid/ready handshake and packs 16 consecutive words into one buffer row, word k going to bank k. It then issues a single-cycle write of that row at a sequentially incrementing 13-bit row address. It sits directly upstream of the feature-map buffer and drives its `fmap_wr_en`, `fmap_wr_addr` and per-bank write-data inputs.

## Interface
Parameters:
- `DATA_W`, 64, width of one bank word
- `NUM_BANKS`, 16, banks per row (words per row)
- `ADDR_W`, 13, row address width

Ports:
- `core_clk` in 1: single clock for all logic
- `core_rst` in 1: reset, asynchronous, active-high
- `start` in 1: one-cycle pulse that launches a load; sampled only in IDLE
- `base_addr` in ADDR_W: first row address; captured on accepted `start`
- `num_rows` in ADDR_W+1: rows to load, 0..8192; captured on accepted `start`
- `in_data` in DATA_W: stream word
- `in_valid` in 1: stream word valid
- `in_ready` out 1: loader can accept a word
- `fmap_wr_en` out 1: row write strobe, one cycle per row
- `fmap_wr_addr` out ADDR_W: row address, valid while `fmap_wr_en`=1
- `fmap_wr_data` out NUM_BANKS*DATA_W: packed row; bank k = bits [64k+63:64k]
- `busy` out 1: load in progress
- `done` out 1: one-cycle pulse after the last row write

## Operation
- FSM states: IDLE, FILL, WRITE, DONE.
- **IDLE:**
  - `start`=1 with `num_rows`≠0: capture `base_addr` and `num_rows`, clear `bank_idx` and `row_cnt`, go to FILL.
  - `start`=1 with `num_rows`=0: go straight to DONE.
- **FILL:**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, store `in_data` in row register slot `bank_idx`, then `bank_idx`++.
  - An accept at `bank_idx`=15 wraps `bank_idx` to 0 and moves to WRITE.
- **WRITE:**
  - `in_ready`=0 for exactly one cycle.
  - `fmap_wr_en`=1, `fmap_wr_addr`=(base + `row_cnt`) mod 8192, `fmap_wr_data`=row register.
  - `row_cnt`++. If the new `row_cnt` equals `num_rows`, go to DONE; otherwise go back to FILL.
- **DONE:** `done`=1 for one cycle, then IDLE.
- `busy`=1 in FILL, WRITE and DONE.
- `start` is ignored outside IDLE.
- Address arithmetic is modulo 2^13. With base=8190 and rows=4, the write addresses are 8190, 8191, 0, 1.
- `in_valid` deasserted mid-row simply stalls. There is no timeout and no partial-row write.
- Stream words presented outside FILL are not accepted (`in_ready`=0).
- `core_rst` asserted at any time returns the FSM to IDLE immediately:
  - All counters are cleared.
  - A partially filled row is discarded and no write is issued.
- The row register does not need a reset.

## Timing
- Reset values: `in_ready`=0, `fmap_wr_en`=0, `fmap_wr_addr`=0, `busy`=0, `done`=0. `fmap_wr_data` is don't-care while `fmap_wr_en`=0.
- All outputs are registered or decoded from registered state only. There is no combinational path from `in_valid` to `in_ready`.
- `start` accepted at cycle 0 → `busy`=1 and `in_ready`=1 from cycle 1.
- 16th accept of a row at cycle t → `fmap_wr_en`=1 at cycle t+1, and `in_ready` is back to 1 at cycle t+2 if rows remain.
- The last row write at cycle w → `done`=1 at w+1, then IDLE with `busy`=0 at w+2.
- `num_rows`=0 start at cycle 0 → `done`=1 at cycle 1, with no write.
- Peak throughput is 1 row per 17 cycles.

## Structure
- Shared package `fmap_pkg` holds:
  - `FMAP_ADDR_W`=13, `FMAP_DATA_W`=64, `FMAP_NUM_BANKS`=16
  - the `fmap_ld_state_t` enum {IDLE, FILL, WRITE, DONE}
- One natural sub-module, `fmap_row_packer`: 16×64-bit register array with indexed write and flat output. The FSM, counters and address adder live in the top.

## Test plan
- **Single row.** base=0x0100, rows=1, 16 back-to-back words 0x0..0xF → one `fmap_wr_en` at addr 0x0100 with bank k = k; `done` one cycle later; `in_ready` low during the write cycle.
- **Stalled stream.** rows=2 with `in_valid` toggling randomly → writes at base and base+1 only after 16 accepts each, data in order, no early or duplicate writes.
- **Address wrap.** base=8190, rows=4 → write addresses 8190, 8191, 0, 1.
- **Zero rows.** rows=0 → `done` at cycle 1, no `fmap_wr_en`, `in_ready` never high.
- **Reset mid-row.** `core_rst` pulsed after 7 words of row 2 → no further writes, all outputs at reset values. A following start with base=0, rows=1 behaves as a clean single-row load.
- **Start while busy.** `start` pulsed with new arguments during FILL → ignored; the original base and row count complete unchanged.
